// File: rtl/qu_common_pkg.sv
// Shared queue/scheduler types: ROB tags and reservation-station entry indices.
package qu_common;

  localparam int unsigned QU_RES_ST_DEPTH = 32;
  localparam int unsigned QU_ROB_DEPTH    = 64;

  typedef logic [$clog2(QU_RES_ST_DEPTH)-1:0] res_st_addr_t;
  typedef logic [$clog2(QU_ROB_DEPTH)-1:0]    rob_addr_t;

endpackage

// File: rtl/res_st_sched_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at N-1.
module rr_picker #(
  parameter  int unsigned N  = 32,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [AW-1:0] idx,
  output logic          valid
);

  logic [AW-1:0] cand;

  // N is a power of two, so AW-bit addition wraps exactly at N.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + AW'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/res_st_sched.sv
// Reservation-station scheduler: entry allocation, tag wakeup and
// round-robin issue of ready entries to a single functional unit.
module res_st_sched
  import qu_common::*;
#(
  parameter int unsigned RES_ST_DEPTH = QU_RES_ST_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            disp_valid,
  output logic                            disp_ready,
  input  rob_addr_t                       disp_qj,
  input  rob_addr_t                       disp_qk,
  output logic                            rs_wr_en,
  output res_st_addr_t                    rs_wr_addr,
  input  logic                            retire_en,
  input  rob_addr_t                       retire_addr,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output res_st_addr_t                    issue_addr,
  output logic [$clog2(RES_ST_DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(RES_ST_DEPTH);
  localparam int unsigned OW = AW + 1;

  logic [RES_ST_DEPTH-1:0] busy, busy_nxt, alloc_oh, ready_vec, pick_gnt, iss_oh;
  rob_addr_t               qj [RES_ST_DEPTH];
  rob_addr_t               qk [RES_ST_DEPTH];
  logic [AW-1:0]           rr_ptr, iss_addr, alloc_addr, pick_ptr, pick_idx;
  logic                    iss_valid, pick_valid, have_free, collide, hs, wr;
  logic [OW-1:0]           occ;

  always_comb begin
    have_free  = 1'b0;
    alloc_addr = '0;
    for (int unsigned i = 0; i < RES_ST_DEPTH; i++) begin
      if (!busy[i] && !have_free) begin
        have_free  = 1'b1;
        alloc_addr = AW'(i);
      end
    end
  end

  // Refuse a micro-op whose source is being broadcast now: its tag would be
  // written after the wakeup and never cleared.
  assign collide = retire_en &&
                   ((disp_qj != '0 && disp_qj == retire_addr) ||
                    (disp_qk != '0 && disp_qk == retire_addr));

  assign disp_ready = !rst && !flush && have_free && !collide;
  assign wr         = disp_valid && disp_ready;
  assign hs         = iss_valid && issue_ready;

  always_comb begin
    alloc_oh = '0;
    if (wr) alloc_oh[alloc_addr] = 1'b1;
    busy_nxt = (busy & ~(hs ? iss_oh : '0)) | alloc_oh;
    for (int unsigned i = 0; i < RES_ST_DEPTH; i++)
      ready_vec[i] = busy[i] && qj[i] == '0 && qk[i] == '0 && !iss_oh[i];
  end

  // On a handshake the replacement is picked from issue_addr+1 in the same
  // cycle, so sustained issue runs one entry per cycle.
  assign pick_ptr = hs ? iss_addr + AW'(1) : rr_ptr;

  rr_picker #(.N(RES_ST_DEPTH)) u_picker (
    .req   (ready_vec),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      rr_ptr    <= '0;
      iss_valid <= 1'b0;
      iss_addr  <= '0;
      iss_oh    <= '0;
      occ       <= '0;
      for (int unsigned i = 0; i < RES_ST_DEPTH; i++) begin
        qj[i] <= '0;
        qk[i] <= '0;
      end
    end else if (flush) begin
      busy      <= '0;
      iss_valid <= 1'b0;
      iss_oh    <= '0;
      occ       <= '0;
    end else begin
      busy <= busy_nxt;
      if (retire_en) begin
        for (int unsigned i = 0; i < RES_ST_DEPTH; i++) begin
          if (busy[i] && qj[i] != '0 && qj[i] == retire_addr) qj[i] <= '0;
          if (busy[i] && qk[i] != '0 && qk[i] == retire_addr) qk[i] <= '0;
        end
      end
      if (wr) begin
        qj[alloc_addr] <= disp_qj;
        qk[alloc_addr] <= disp_qk;
      end
      if (hs) rr_ptr <= iss_addr + AW'(1);
      if (hs || !iss_valid) begin
        iss_valid <= pick_valid;
        iss_addr  <= pick_idx;
        iss_oh    <= pick_gnt;
      end
      if (wr && !hs)      occ <= occ + OW'(1);
      else if (!wr && hs) occ <= occ - OW'(1);
    end
  end

  assign rs_wr_en    = wr;
  assign rs_wr_addr  = res_st_addr_t'(alloc_addr);
  assign issue_valid = iss_valid;
  assign issue_addr  = res_st_addr_t'(iss_addr);
  assign occupancy   = occ;

endmodule

// File: tb/tb_res_st_sched.sv
// Directed bench for res_st_sched: entry-set model checked every cycle plus
// hand-computed scenario expectations.
module tb_res_st_sched;
  import qu_common::*;

  localparam int D = 32;

  logic         clk, rst, flush, disp_valid, disp_ready, rs_wr_en;
  logic         retire_en, issue_valid, issue_ready;
  rob_addr_t    disp_qj, disp_qk, retire_addr;
  res_st_addr_t rs_wr_addr, issue_addr;
  logic [5:0]   occupancy;

  res_st_sched #(.RES_ST_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .rs_wr_en(rs_wr_en), .rs_wr_addr(rs_wr_addr),
    .retire_en(retire_en), .retire_addr(retire_addr),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_addr(issue_addr), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit running = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the set of occupied entries with their pending tags, the entry
  // currently offered to the FU and the round-robin start point.
  bit m_busy [D];
  int m_qj [D];
  int m_qk [D];
  int m_rr = 0;
  bit m_iv = 0;
  int m_ia = 0;

  function automatic int first_free();
    for (int i = 0; i < D; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int n_busy();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit exp_ready();
    if (rst || flush || first_free() < 0) return 0;
    if (retire_en && ((disp_qj != 0 && disp_qj == retire_addr) ||
                      (disp_qk != 0 && disp_qk == retire_addr))) return 0;
    return 1;
  endfunction

  int mw_slot, mw_start, mw_next;
  bit mw_wr, mw_hs, mw_nv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin m_busy[i] = 0; m_qj[i] = 0; m_qk[i] = 0; end
      m_rr = 0; m_iv = 0; m_ia = 0;
    end else begin
      mw_wr   = disp_valid && exp_ready();
      mw_slot = first_free();
      mw_hs   = m_iv && issue_ready;
      mw_nv   = m_iv && !mw_hs;
      mw_next = m_ia;
      if (!m_iv || mw_hs) begin
        mw_start = mw_hs ? (m_ia + 1) % D : m_rr;
        for (int k = 0; k < D; k++) begin
          int j;
          j = (mw_start + k) % D;
          if (!mw_nv && m_busy[j] && m_qj[j] == 0 && m_qk[j] == 0 && !(m_iv && j == m_ia)) begin
            mw_nv = 1; mw_next = j;
          end
        end
      end
      if (flush) begin
        for (int i = 0; i < D; i++) m_busy[i] = 0;
        m_iv = 0;
      end else begin
        if (mw_hs) begin m_busy[m_ia] = 0; m_rr = (m_ia + 1) % D; end
        if (retire_en)
          for (int i = 0; i < D; i++) if (m_busy[i]) begin
            if (m_qj[i] == int'(retire_addr)) m_qj[i] = 0;
            if (m_qk[i] == int'(retire_addr)) m_qk[i] = 0;
          end
        if (mw_wr) begin
          m_busy[mw_slot] = 1; m_qj[mw_slot] = int'(disp_qj); m_qk[mw_slot] = int'(disp_qk);
        end
        m_iv = mw_nv;
        if (mw_nv) m_ia = mw_next;
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      check("disp_ready", disp_ready, exp_ready());
      check("rs_wr_en", rs_wr_en, disp_valid && exp_ready());
      if (disp_valid && exp_ready()) check("rs_wr_addr", rs_wr_addr, first_free());
      check("issue_valid", issue_valid, m_iv);
      if (m_iv || rst) check("issue_addr", issue_addr, rst ? 0 : m_ia);
      check("occupancy", occupancy, n_busy());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic disp(input int qj, input int qk);
    disp_valid = 1'b1;
    disp_qj    = rob_addr_t'(qj);
    disp_qk    = rob_addr_t'(qk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_qj = '0; disp_qk = '0;
    retire_en = 1'b0; retire_addr = '0; issue_ready = 1'b0;
    tick(); #1;
    check("rst_disp_ready", disp_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_addr", issue_addr, 0);
    running = 1;
    tick(); rst = 1'b0;

    // fill all entries in index order
    for (int k = 0; k < D; k++) begin
      disp(0, 0); #1;
      check("fill_addr", rs_wr_addr, k);
      check("fill_ready", disp_ready, 1);
      tick();
    end
    #1;
    check("full_disp_ready", disp_ready, 0);
    check("full_wr_en", rs_wr_en, 0);
    check("full_occupancy", occupancy, 32);
    check("full_issue_addr", issue_addr, 0);
    disp_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0; #1;
    check("flush_occ", occupancy, 0);

    // wakeup of entry 3 after tags 5 and 7 retire
    for (int k = 0; k < 3; k++) begin disp(20, 0); tick(); end
    disp(5, 7); #1; check("wake_alloc", rs_wr_addr, 3);
    tick(); disp_valid = 1'b0; tick(); tick(); #1;
    check("wake_idle", issue_valid, 0);
    retire_en = 1'b1; retire_addr = 6'd5; tick();
    retire_addr = 6'd7; tick(); retire_en = 1'b0; #1;
    check("wake_early", issue_valid, 0);
    tick(); #1;
    check("wake_valid", issue_valid, 1);
    check("wake_addr", issue_addr, 3);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0; #1;
    check("wake_occ", occupancy, 3);

    // fairness: 0,1,2 back to back, re-dispatched entry 0 follows 2
    issue_ready = 1'b1; retire_en = 1'b1; retire_addr = 6'd20; tick();
    retire_en = 1'b0; #1; check("fair_wait", issue_valid, 0);
    tick(); #1; check("fair_0", issue_addr, 0);
    tick(); disp(0, 0); #1;
    check("fair_1", issue_addr, 1);
    check("fair_realloc", rs_wr_addr, 0);
    tick(); disp_valid = 1'b0; #1; check("fair_2", issue_addr, 2);
    tick(); #1;
    check("fair_again_v", issue_valid, 1);
    check("fair_again_0", issue_addr, 0);
    tick(); issue_ready = 1'b0; #1;
    check("fair_drained", occupancy, 0);

    // collision with same-cycle broadcast
    disp(9, 0); retire_en = 1'b1; retire_addr = 6'd9; #1;
    check("coll_ready", disp_ready, 0);
    check("coll_wr_en", rs_wr_en, 0);
    tick(); retire_en = 1'b0; #1;
    check("coll_accept", rs_wr_en, 1);
    check("coll_addr", rs_wr_addr, 0);
    tick();

    // backpressure holds the offer; freed entry reused afterwards
    disp(0, 0); #1; check("bp_alloc", rs_wr_addr, 1);
    tick(); disp_valid = 1'b0; tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_valid", issue_valid, 1);
      check("bp_addr", issue_addr, 1);
      check("bp_occ", occupancy, 2);
      tick();
    end
    issue_ready = 1'b1; #1; check("bp_hs_addr", issue_addr, 1);
    tick(); issue_ready = 1'b0; disp(0, 0); #1;
    check("bp_reuse", rs_wr_addr, 1);
    check("bp_occ_after", occupancy, 1);
    tick(); disp_valid = 1'b0;

    // flush with ten busy entries and an offer pending
    for (int k = 0; k < 8; k++) begin disp(0, 0); #1; check("fl_alloc", rs_wr_addr, 2 + k); tick(); end
    disp_valid = 1'b0; tick(); #1;
    check("fl_occ10", occupancy, 10);
    check("fl_iv", issue_valid, 1);
    check("fl_ia", issue_addr, 1);
    flush = 1'b1; disp(0, 0); issue_ready = 1'b1; #1;
    check("fl_ready", disp_ready, 0);
    tick(); flush = 1'b0; disp_valid = 1'b0; issue_ready = 1'b0; #1;
    check("fl_occ0", occupancy, 0);
    check("fl_iv0", issue_valid, 0);

    // async reset in the middle of a handshake
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin disp(0, 0); tick(); end
    disp_valid = 1'b0; tick(); #1;
    check("ar_busy_iv", issue_valid, 1);
    rst = 1'b1; #1;
    check("ar_iv", issue_valid, 0);
    check("ar_ia", issue_addr, 0);
    check("ar_occ", occupancy, 0);
    check("ar_dr", disp_ready, 0);
    check("ar_wr", rs_wr_en, 0);
    issue_ready = 1'b0; tick(); tick(); rst = 1'b0;
    disp(0, 0); #1; check("ar_alloc", rs_wr_addr, 0);
    tick(); disp_valid = 1'b0; #1; check("ar_iv1", issue_valid, 0);
    tick(); #1;
    check("ar_iv2", issue_valid, 1);
    check("ar_ia2", issue_addr, 0);
    check("ar_occ2", occupancy, 1);
    issue_ready = 1'b1; tick(); tick(); tick();
    running = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
